// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants, entry type and width helper for the fetch queue
package fetch_queue_pkg;
  localparam int DEPTH_DEF = 4;
  localparam logic [31:0] NOP_INSTR = 32'd0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  // counters and pointers need one extra bit so that DEPTH itself is representable
  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, redirect and decode-side handshake bundle
//   master = fetch_queue side, slave = imem / pipeline side
interface fetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: circular buffer of {pc, instr} entries
//   i_clk, i_rst_n (async active-low), i_wr/i_wdata enqueue, i_rd dequeue, i_clr flush,
//   o_rdata head entry, o_empty, o_count occupancy
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr,
  input  fetch_entry_t              i_wdata,
  input  logic                      i_rd,
  input  logic                      i_clr,
  output fetch_entry_t              o_rdata,
  output logic                      o_empty,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_full;
  // pointers carry an extra lap bit: equal means empty, lap differs with equal index means full
  assign o_count = r_wp - r_rp;
  assign o_empty = r_wp == r_rp;
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_rdata = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_clr) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_wr) assert (!w_full);
      if (i_wr) r_wp <= r_wp + (AW+1)'(1);
      if (i_rd) r_rp <= r_rp + (AW+1)'(1);
    end
  always_ff @(posedge i_clk)
    if (i_wr && !i_clr) r_mem[r_wp[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order imem fetch front end with credit-limited requests, redirect flush and output queue
//   i_clk, i_rst_n (async active-low), fq (fetch_queue_if.master: imem req/rsp, redirect, out handshake)
//   Optional FETCH_QUEUE_BYPASS_EN: a response arriving at an empty, non-draining queue drives out_* directly
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fetch_queue_if.master fq
);
  localparam int CW = cnt_w(DEPTH);
  logic [31:0] r_fetch_pc, r_rsp_pc;
  logic [CW-1:0] r_inflight, r_drop, w_count, w_count_nx, w_inflight_nx;
  logic r_req_valid, w_fire, w_take, w_byp, w_wr, w_rd, w_empty;
  fetch_entry_t w_head, w_wdata;
  assign w_fire = r_req_valid & fq.imem_req_ready;
  // a response is kept only when nothing stale is pending and no redirect is flushing this cycle
  assign w_take = fq.imem_rsp_valid & ~fq.redirect_valid & (r_drop == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_take & w_empty;
`else
  assign w_byp = 1'b0;
`endif
  assign w_wr = w_take & ~(w_byp & fq.out_ready);
  assign w_rd = ~w_empty & fq.out_ready;
  assign w_wdata = '{pc: r_rsp_pc, instr: fq.imem_rsp_data};
  assign w_inflight_nx = r_inflight + CW'(w_fire) - CW'(fq.imem_rsp_valid);
  assign w_count_nx = fq.redirect_valid ? '0 : w_count + CW'(w_wr) - CW'(w_rd);
  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (w_rd),
    .i_clr   (fq.redirect_valid),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  assign fq.imem_req_valid = r_req_valid;
  assign fq.imem_req_addr  = r_fetch_pc;
  assign fq.out_valid      = ~w_empty | w_byp;
  assign fq.out_pc         = ~w_empty ? w_head.pc : w_byp ? r_rsp_pc : 32'd0;
  assign fq.out_instr      = ~w_empty ? w_head.instr : w_byp ? fq.imem_rsp_data : NOP_INSTR;
  // req_valid is registered from next-state occupancy so it never depends combinationally on inputs
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_req_valid <= 1'b0;
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_inflight  <= '0;
      r_drop      <= '0;
    end else begin
      r_req_valid <= ({1'b0, w_count_nx} + {1'b0, w_inflight_nx}) < (CW+1)'(DEPTH);
      r_fetch_pc  <= fq.redirect_valid ? fq.redirect_pc : r_fetch_pc + 32'(w_fire);
      r_rsp_pc    <= fq.redirect_valid ? fq.redirect_pc : r_rsp_pc + 32'(w_take);
      r_inflight  <= w_inflight_nx;
      r_drop      <= fq.redirect_valid ? w_inflight_nx :
                     (fq.imem_rsp_valid && r_drop != '0) ? r_drop - CW'(1) : r_drop;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a latency-configurable in-order imem model
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  fetch_queue_if fq();
  fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .fq      (fq)
  );
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int n_fire = 0;
  logic [31:0] fire_log [64];
  logic [31:0] q_addr [$];
  int q_due [$];
  function automatic logic [31:0] word(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    if (fq.imem_req_valid && fq.imem_req_ready) begin
      if (n_fire < 64) fire_log[n_fire] = fq.imem_req_addr;
      n_fire++;
      q_addr.push_back(fq.imem_req_addr);
      q_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      fq.imem_rsp_valid = 1'b1;
      fq.imem_rsp_data  = word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      fq.imem_rsp_valid = 1'b0;
      fq.imem_rsp_data  = 32'd0;
    end
    #1;
  endtask
  task automatic do_reset(int l);
    rst_n = 1'b0;
    lat = l;
    q_addr.delete();
    q_due.delete();
    n_fire = 0;
    fq.imem_req_ready = 1'b1;
    fq.imem_rsp_valid = 1'b0;
    fq.imem_rsp_data  = 32'd0;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc    = 32'd0;
    fq.out_ready      = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    #1;
  endtask
  task automatic wait_out(string tag);
    for (int i = 0; i < 20 && !fq.out_valid; i++) tick();
    check({tag, "_wait"}, 32'(fq.out_valid), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    // reset state
    do_reset(1);
    check("rst_req_valid", 32'(fq.imem_req_valid), 32'd0);
    check("rst_out_valid", 32'(fq.out_valid), 32'd0);
    check("rst_addr", fq.imem_req_addr, 32'd0);
    // 1: steady stream with 1-cycle imem
    wait_out("t1");
    for (int i = 0; i < 6; i++) begin
      check("t1_valid", 32'(fq.out_valid), 32'd1);
      check("t1_pc", fq.out_pc, 32'(i));
      check("t1_instr", fq.out_instr, word(32'(i)));
      tick();
    end
    // 2: decode stalled, credits cap requests at DEPTH
    do_reset(1);
    fq.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t2_nfire", 32'(n_fire), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_addr", fire_log[i], 32'(i));
    check("t2_req_valid_full", 32'(fq.imem_req_valid), 32'd0);
    check("t2_out_pc_head", fq.out_pc, 32'd0);
    fq.out_ready = 1'b1;
    tick();
    check("t2_req_valid_rel", 32'(fq.imem_req_valid), 32'd1);
    check("t2_addr_rel", fq.imem_req_addr, 32'd4);
    check("t2_out_pc_next", fq.out_pc, 32'd1);
    // 3: 3-cycle imem, redirect with three requests in flight
    do_reset(3);
    tick();
    tick();
    tick();
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = 32'h40;
    tick();
    fq.redirect_valid = 1'b0;
    check("t3_addr", fq.imem_req_addr, 32'h40);
    wait_out("t3");
    check("t3_pc", fq.out_pc, 32'h40);
    check("t3_instr", fq.out_instr, word(32'h40));
    tick();
    check("t3_valid2", 32'(fq.out_valid), 32'd1);
    check("t3_pc2", fq.out_pc, 32'h41);
    // 4: redirect coinciding with a request fire and a response
    do_reset(1);
    tick();
    tick();
    check("t4_pre_fire", 32'(fq.imem_req_valid), 32'd1);
    check("t4_pre_rsp", 32'(fq.imem_rsp_valid), 32'd1);
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = 32'h80;
    tick();
    fq.redirect_valid = 1'b0;
    check("t4_out_flushed", 32'(fq.out_valid), 32'd0);
    check("t4_addr", fq.imem_req_addr, 32'h80);
    wait_out("t4");
    check("t4_pc", fq.out_pc, 32'h80);
    check("t4_instr", fq.out_instr, word(32'h80));
    // 5: asynchronous reset mid-stream
    do_reset(2);
    for (int i = 0; i < 5; i++) tick();
    check("t5_pre_valid", 32'(fq.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_req_valid", 32'(fq.imem_req_valid), 32'd0);
    check("t5_addr", fq.imem_req_addr, 32'd0);
    check("t5_out_valid", 32'(fq.out_valid), 32'd0);
    check("t5_out_pc", fq.out_pc, 32'd0);
    check("t5_out_instr", fq.out_instr, 32'd0);
    do_reset(1);
    for (int i = 0; i < 3; i++) tick();
    check("t5_first_addr", fire_log[0], 32'd0);
    // 6: first response into an empty queue
    do_reset(1);
    tick();
    tick();
    check("t6_rsp", 32'(fq.imem_rsp_valid), 32'd1);
    check("t6_valid_T", 32'(fq.out_valid), 32'(BYP));
    tick();
    check("t6_valid_T1", 32'(fq.out_valid), 32'd1);
    check("t6_pc_T1", fq.out_pc, BYP ? 32'd1 : 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
